// File: rtl/subtractor_pkg.sv
// Shared constants and FSM encoding for the multi-word subtract datapath.
package subtractor_pkg;
  localparam int WORD_W = 32;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_e;
endpackage

// File: rtl/binary_subtractor_32_bit_using_subtractors.sv
// Combinational 32-bit ripple-borrow subtractor built from 1-bit full subtractors.
module binary_subtractor_32_bit_using_subtractors
  import subtractor_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic              b0,
  output logic [WORD_W-1:0] d,
  output logic              b32
);
  logic [WORD_W:0] b;

  assign b[0] = b0;

  for (genvar i = 0; i < WORD_W; i++) begin : g_fs
    assign d[i]   = x[i] ^ y[i] ^ b[i];
    assign b[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b[i]);
  end

  assign b32 = b[WORD_W];
endmodule

// File: rtl/multiword_subtract_sequencer.sv
// Chains an external 32-bit subtractor across operand words (LSW first) with a
// registered valid/ready output stage and per-operation zero/borrow flags.
module multiword_subtract_sequencer
  import subtractor_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_x,
  input  logic [WORD_W-1:0] in_y,
  input  logic              in_last,
  output logic [WORD_W-1:0] sub_x,
  output logic [WORD_W-1:0] sub_y,
  output logic              sub_b0,
  input  logic [WORD_W-1:0] sub_d,
  input  logic              sub_b32,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_d,
  output logic              out_last,
  output logic              out_borrow,
  output logic              out_zero,
  output logic              len_err
);
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e            state_q, state_d;
  logic              borrow_q, borrow_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              zacc_q, zacc_d;
  logic              vld_q, vld_d;
  logic [WORD_W-1:0] d_q, d_d;
  logic              last_q, last_d;
  logic              bout_q, bout_d;
  logic              zero_q, zero_d;
  logic              lerr_q, lerr_d;

  logic accept, zacc_n, forced, is_last;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign sub_x    = in_x;
  assign sub_y    = in_y;
  assign sub_b0   = borrow_q;

  assign zacc_n  = zacc_q && (sub_d == '0);
  // Operand overran the word budget: close it here and flag the error.
  assign forced  = !in_last && (cnt_q == CW'(WORDS - 1));
  assign is_last = in_last || forced;

  always_comb begin
    state_d  = state_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    zacc_d   = zacc_q;
    vld_d    = vld_q;
    d_d      = d_q;
    last_d   = last_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    lerr_d   = lerr_q;
    if (accept) begin
      vld_d = 1'b1;
      d_d   = sub_d;
      if (is_last) begin
        last_d   = 1'b1;
        bout_d   = sub_b32;
        zero_d   = zacc_n;
        state_d  = ST_FIRST;
        borrow_d = 1'b0;
        cnt_d    = '0;
        zacc_d   = 1'b1;
        if (forced) lerr_d = 1'b1;
      end else begin
        last_d   = 1'b0;
        bout_d   = 1'b0;
        zero_d   = 1'b0;
        state_d  = ST_MID;
        borrow_d = sub_b32;
        cnt_d    = cnt_q + 1'b1;
        zacc_d   = zacc_n;
      end
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FIRST;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      zacc_q   <= 1'b1;
      vld_q    <= 1'b0;
      d_q      <= '0;
      last_q   <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      zacc_q   <= zacc_d;
      vld_q    <= vld_d;
      d_q      <= d_d;
      last_q   <= last_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      lerr_q   <= lerr_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_d      = d_q;
  assign out_last   = last_q;
  assign out_borrow = bout_q;
  assign out_zero   = zero_q;
  assign len_err    = lerr_q;
endmodule

// File: tb/tb_multiword_subtract_sequencer.sv
// Scoreboard bench: big-integer reference model feeds an expectation queue,
// a negedge monitor pops and compares every delivered difference word.
module tb_multiword_subtract_sequencer;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_x, in_y, sub_x, sub_y, sub_d, out_d;
  logic        sub_b0, sub_b32;
  logic        out_valid, out_ready, out_last, out_borrow, out_zero, len_err;

  always #5 clk = ~clk;

  multiword_subtract_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .sub_x(sub_x), .sub_y(sub_y), .sub_b0(sub_b0), .sub_d(sub_d), .sub_b32(sub_b32),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_last(out_last),
    .out_borrow(out_borrow), .out_zero(out_zero), .len_err(len_err)
  );

  binary_subtractor_32_bit_using_subtractors u_sub (
    .x(sub_x), .y(sub_y), .b0(sub_b0), .d(sub_d), .b32(sub_b32)
  );

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic        borrow;
    logic        zero;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          bp_mode = 0;
  int          bp_hold = 0;
  logic [31:0] sx[16], sy[16];
  logic        sl[16];
  logic        eb0[16];
  int          sn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Operands as plain integers per chunk; chunks close on in_last or WORDS words.
  task automatic build_expect();
    logic [159:0] X, Y, D;
    int   k;
    logic closing;
    exp_t e;
    X = '0; Y = '0; k = 0;
    for (int i = 0; i < sn; i++) begin
      eb0[i] = (X < Y);
      X = X | (160'(sx[i]) << (32 * k));
      Y = Y | (160'(sy[i]) << (32 * k));
      k++;
      closing = sl[i] || (k == WORDS);
      if (closing || i == sn - 1) begin
        D = X - Y;
        for (int j = 0; j < k; j++) begin
          e.d      = D[32*j +: 32];
          e.last   = closing && (j == k - 1);
          e.borrow = e.last && (X < Y);
          e.zero   = e.last && (X == Y);
          exp_q.push_back(e);
        end
        X = '0; Y = '0; k = 0;
      end
    end
  endtask

  task automatic run_stream();
    int w;
    build_expect();
    for (int i = 0; i < sn; i++) begin
      in_valid = 1'b1;
      in_x     = sx[i];
      in_y     = sy[i];
      in_last  = sl[i];
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        tests++; fails++;
        $display("FAIL accept_timeout: in_ready got 0 expected 1 at word %0d", i);
      end else begin
        check("sub_b0", {31'b0, sub_b0}, {31'b0, eb0[i]});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d words outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input logic exp_lerr);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_d", out_d, 32'd0);
    check("rst_flags", {29'b0, out_last, out_borrow, out_zero}, 32'd0);
    check("rst_len_err", {31'b0, len_err}, {31'b0, exp_lerr});
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_sub_b0", {31'b0, sub_b0}, 32'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (bp_hold > 0) begin
        out_ready = 1'b0;
        bp_hold--;
      end else if (bp_mode != 0) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
    end
  end

  initial begin : monitor
    logic        stall_prev = 1'b0;
    logic [31:0] held_d;
    logic        held_last;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid) begin
          check("hold_d", out_d, held_d);
          check("hold_last", {31'b0, out_last}, {31'b0, held_last});
        end
        if (out_valid && !out_ready) check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_word: got %h expected none", out_d);
          end else begin
            e = exp_q.pop_front();
            check("out_d", out_d, e.d);
            check("out_flags", {29'b0, out_last, out_borrow, out_zero},
                  {29'b0, e.last, e.borrow, e.zero});
          end
        end
        stall_prev = out_valid && !out_ready;
        held_d     = out_d;
        held_last  = out_last;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle(1'b0);
    @(posedge clk); #1;

    // equal 128-bit operands
    sn = 4;
    for (int i = 0; i < 4; i++) begin sx[i] = 32'hAAAAAAAA; sy[i] = 32'hAAAAAAAA; sl[i] = (i == 3); end
    run_stream(); drain();

    // borrow crosses a word boundary
    sn = 2;
    sx[0] = 32'h0; sy[0] = 32'h1; sl[0] = 1'b0;
    sx[1] = 32'h1; sy[1] = 32'h0; sl[1] = 1'b1;
    run_stream(); drain();

    sn = 1; sx[0] = 32'd5; sy[0] = 32'd7; sl[0] = 1'b1;
    run_stream(); drain();

    // back-pressure mid-operation
    sn = 4;
    for (int i = 0; i < 4; i++) begin sx[i] = $urandom; sy[i] = $urandom; sl[i] = (i == 3); end
    fork
      run_stream();
      begin repeat (2) @(posedge clk); bp_hold = 3; end
    join
    drain();

    check("len_err_pre", {31'b0, len_err}, 32'd0);
    sn = 6;
    for (int i = 0; i < 6; i++) begin sx[i] = $urandom; sy[i] = $urandom; sl[i] = (i == 5); end
    run_stream(); drain();
    check("len_err_sticky", {31'b0, len_err}, 32'd1);

    // reset after two words of a four-word operation
    sn = 2;
    for (int i = 0; i < 2; i++) begin sx[i] = $urandom; sy[i] = $urandom; sl[i] = 1'b0; end
    sy[0] = sx[0] + 32'd1;
    run_stream(); drain();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle(1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    sn = 1; sx[0] = 32'd9; sy[0] = 32'd4; sl[0] = 1'b1;
    run_stream(); drain();

    for (int t = 0; t < 40; t++) begin
      bp_mode = int'($urandom_range(0, 1));
      sn = int'($urandom_range(1, 7));
      for (int i = 0; i < sn; i++) begin
        sx[i] = $urandom;
        case ($urandom_range(0, 3))
          0:       sy[i] = sx[i];
          1:       sy[i] = sx[i] + 32'd1;
          default: sy[i] = $urandom;
        endcase
        sl[i] = (i == sn - 1) || ($urandom_range(0, 4) == 0);
      end
      run_stream();
    end
    bp_mode = 0;
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
